pipeline_stall_scheduler: RTL

Sequential stall/flush controller for the 5-stage MIPS pipeline. It takes the hazard classifications produced in ID: load-use, branch-after-load at EX or MEM distance, branch-after-ALU, and taken branch/jump. It also takes handshakes from a multi-cycle mul/div unit in EX. From these it drives the per-stage write enables, bubble inserts and the IF/ID flush. It owns multi-cycle stall sequencing and stall/flush performance counters, so the combinational hazard detector only reports conditions.

---
 rtl/pipeline_stall_scheduler_if.sv | 39 +++
 rtl/pipeline_stall_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_scheduler_if.sv
// Hazard-report inputs, stage-control outputs and performance counters of
// the pipeline stall scheduler, bundled for the scheduler and its driver.
interface pipeline_stall_scheduler_if #(
  parameter int PERF_W = 32
);
  logic              load_use;
  logic              br_load_ex;
  logic              br_load_mem;
  logic              br_alu_ex;
  logic              branch_taken;
  logic              md_start;
  logic              md_done;
  logic              perf_clear;
  logic              pc_write;
  logic              IF_ID_write;
  logic              IF_ID_flush;
  logic              ID_EX_write;
  logic              ID_EX_bubble;
  logic              EX_MEM_bubble;
  logic              md_timeout;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  // Hazard detector / pipeline side: drives requests, observes controls.
  modport master (
    output load_use, br_load_ex, br_load_mem, br_alu_ex, branch_taken,
           md_start, md_done, perf_clear,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           EX_MEM_bubble, md_timeout, stall_cycles, flush_count
  );

  // Scheduler side.
  modport slave (
    input  load_use, br_load_ex, br_load_mem, br_alu_ex, branch_taken,
           md_start, md_done, perf_clear,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           EX_MEM_bubble, md_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_scheduler.sv
// Stall/flush sequencer for the 5-stage pipeline. Hazard classes reported by
// ID are turned into per-stage write enables, bubble inserts and the IF/ID
// flush in the same cycle; multi-cycle stalls (branch-after-load in EX and
// mul/div waits) are sequenced here, along with stall/flush counters.
module pipeline_stall_scheduler #(
  parameter int MD_MAX_CYCLES = 64,
  parameter int PERF_W        = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  pipeline_stall_scheduler_if.slave     bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  localparam int                WAIT_W    = $clog2(MD_MAX_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_MAX_CYCLES - 1);
  localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

  state_t            state_r;
  logic [1:0]        remaining_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              md_timeout_r;
  logic [PERF_W-1:0] stall_cycles_r;
  logic [PERF_W-1:0] flush_count_r;

  logic front_s;
  logic full_s;
  logic flush_s;
  logic release_s;
  logic timeout_s;
  logic front_hazard_s;

  logic pc_write_s;
  logic if_id_write_s;
  logic if_id_flush_s;
  logic id_ex_write_s;
  logic id_ex_bubble_s;
  logic ex_mem_bubble_s;

  assign front_hazard_s = bus.br_load_ex | bus.load_use | bus.br_load_mem | bus.br_alu_ex;

  // Classify this cycle as front stall, full stall, flush or plain run.
  always_comb begin
    front_s   = 1'b0;
    full_s    = 1'b0;
    flush_s   = 1'b0;
    release_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.md_start) begin
          full_s = 1'b1;
        end else if (front_hazard_s) begin
          front_s = 1'b1;
        end else if (bus.branch_taken) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      STALL: begin
        front_s = 1'b1;
      end
      MD_WAIT: begin
        if (bus.md_done) begin
          release_s = 1'b1;
        end else if (wait_cnt_r == WAIT_LAST) begin
          release_s = 1'b1;
          timeout_s = 1'b1;
        end else begin
          full_s = 1'b1;
        end
      end
      default: begin
        front_s = 1'b0;
      end
    endcase
  end

  // Map the cycle class onto stage controls; reset forces a frozen, bubbled pipe.
  always_comb begin
    pc_write_s      = 1'b1;
    if_id_write_s   = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_write_s   = 1'b1;
    id_ex_bubble_s  = 1'b0;
    ex_mem_bubble_s = 1'b0;
    if (!rstn) begin
      pc_write_s      = 1'b0;
      if_id_write_s   = 1'b0;
      id_ex_write_s   = 1'b0;
      id_ex_bubble_s  = 1'b1;
      ex_mem_bubble_s = 1'b1;
    end else if (full_s) begin
      pc_write_s      = 1'b0;
      if_id_write_s   = 1'b0;
      id_ex_write_s   = 1'b0;
      ex_mem_bubble_s = 1'b1;
    end else if (front_s) begin
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      id_ex_bubble_s = 1'b1;
    end else begin
      if_id_flush_s = flush_s;
    end
  end

  // Stall sequencing state machine with the sticky mul/div timeout flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= RUN;
      remaining_r  <= 2'd0;
      wait_cnt_r   <= '0;
      md_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.md_start) begin
            state_r    <= MD_WAIT;
            wait_cnt_r <= '0;
          end else if (bus.br_load_ex) begin
            state_r     <= STALL;
            remaining_r <= 2'd1;
          end else begin
            state_r <= RUN;
          end
        end
        STALL: begin
          remaining_r <= remaining_r - 2'd1;
          if (remaining_r <= 2'd1) begin
            state_r <= RUN;
          end else begin
            state_r <= STALL;
          end
        end
        MD_WAIT: begin
          if (release_s) begin
            state_r <= RUN;
            if (timeout_s) begin
              md_timeout_r <= 1'b1;
            end else begin
              md_timeout_r <= md_timeout_r;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Saturating stall/flush counters; a clear request beats any increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles_r <= '0;
      flush_count_r  <= '0;
    end else if (bus.perf_clear) begin
      stall_cycles_r <= '0;
      flush_count_r  <= '0;
    end else begin
      if (!pc_write_s && (stall_cycles_r != PERF_MAX)) begin
        stall_cycles_r <= stall_cycles_r + PERF_W'(1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (if_id_flush_s && (flush_count_r != PERF_MAX)) begin
        flush_count_r <= flush_count_r + PERF_W'(1);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign bus.pc_write      = pc_write_s;
  assign bus.IF_ID_write   = if_id_write_s;
  assign bus.IF_ID_flush   = if_id_flush_s;
  assign bus.ID_EX_write   = id_ex_write_s;
  assign bus.ID_EX_bubble  = id_ex_bubble_s;
  assign bus.EX_MEM_bubble = ex_mem_bubble_s;
  assign bus.md_timeout    = md_timeout_r;
  assign bus.stall_cycles  = stall_cycles_r;
  assign bus.flush_count   = flush_count_r;

endmodule
